// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and defaults for the UART command wrapper
package maze_pkg;

  typedef enum logic {
    RX_HIGH = 1'b0,
    RX_LOW  = 1'b1
  } rx_state_t;

  localparam logic [7:0] DEFAULT_RESP_BYTE = 8'hA5;
  localparam int         DEFAULT_TMO_CYC   = 1_000_000;

endpackage

// File: rtl/resp_tx_ctrl.sv
// rtl/resp_tx_ctrl.sv - response transmit launcher with one-deep pending request
module resp_tx_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic send_resp,
  input  logic tx_done,
  output logic trmt
);

  logic busy;
  logic pending;
  logic tx_free;
  logic launch_pend;
  logic launch_new;
  logic trmt_nxt;

  // tx_done frees the transmitter in the same cycle, so a waiting request can launch immediately
  assign tx_free     = !busy || tx_done;
  assign launch_pend = pending && tx_free;
  assign launch_new  = send_resp && !pending && tx_free;
  assign trmt_nxt    = launch_pend || launch_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      trmt    <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
    end else begin
      trmt <= trmt_nxt;
      if (trmt_nxt) begin
        busy <= 1'b1;
      end else if (tx_done) begin
        busy <= 1'b0;
      end
      if (pending) begin
        pending <= !launch_pend;
      end else begin
        pending <= send_resp && !tx_free;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - assembles 16-bit commands from UART bytes and launches response bytes
module uart_cmd_wrapper
  import maze_pkg::*;
#(
  parameter logic [7:0] RESP_BYTE = DEFAULT_RESP_BYTE,
  parameter int         TMO_CYC   = DEFAULT_TMO_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done
);

  localparam int              CNT_W    = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             cap_hi;
  logic             cap_lo;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_HIGH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_HIGH: if (rx_rdy) state_nxt = RX_LOW;
      RX_LOW:  if (rx_rdy || tmo_hit) state_nxt = RX_HIGH;
      default: state_nxt = RX_HIGH;
    endcase
  end

  // Acknowledge is combinational so the receiver drops rx_rdy right after the capture edge
  always_comb begin
    clr_rx_rdy = 1'b0;
    cap_hi     = 1'b0;
    cap_lo     = 1'b0;
    if (!rst && rx_rdy) begin
      clr_rx_rdy = 1'b1;
      cap_hi     = (state == RX_HIGH);
      cap_lo     = (state == RX_LOW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= 16'h0000;
      cmd_rdy <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (cap_hi) begin
        cmd[15:8] <= rx_data;
        cmd_rdy   <= 1'b0;
        tmo_cnt   <= '0;
      end else if (cap_lo) begin
        cmd[7:0] <= rx_data;
        cmd_rdy  <= 1'b1;
      end else begin
        if (clr_cmd_rdy) begin
          cmd_rdy <= 1'b0;
        end
        if (state == RX_LOW) begin
          tmo_cnt <= tmo_hit ? '0 : tmo_cnt + 1'b1;
        end
      end
    end
  end

  assign tx_data = RESP_BYTE;

  resp_tx_ctrl u_resp_tx_ctrl (
    .clk       (clk),
    .rst       (rst),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .trmt      (trmt)
  );

endmodule
